instram_dp: RTL
===============

# instram_dp

Parametrised simple-dual-port instruction memory: one synchronous read port, one write port with ready handshake, optional output pipeline stage, optional write-to-read bypass, and a built-in sequential clear engine. It is the next-generation code store between the loader (write side) and the CPU fetch path (read side). It is sized exactly by parameter, so no address bits are wasted.

## Interface
- ADDR_W, 15, address width; depth = 2^ADDR_W words
- DATA_W, 8, word width
- RD_PIPE, 0, 0 or 1; adds an output register stage to the read path
- BYPASS, 1, 1 = a same-cycle write to the read address returns the new data; 0 = returns old data
- INIT_VAL, 0, DATA_W-bit word written by the clear engine
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_en  in  1  read request
- rd_adr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data; holds its value when no read completes
- rd_valid  out  1  one-cycle pulse when rd_data carries a completed read
- wr_en  in  1  write request
- wr_adr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  write port can accept; a write occurs when wr_en && wr_ready
- clr_start  in  1  pulse to start a clear of the whole array
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse after the last clear write

## Operation
- Reset: rd_data=0, rd_valid=0, clr_busy=0, clr_done=0, wr_ready=1, FSM=IDLE, clear counter=0.
  - Array contents are not reset.
  - Array has no reset connection, so it infers block RAM.
- Read: when rd_en is high, the word at rd_adr is captured. rd_en low leaves rd_data unchanged and rd_valid=0.
- Write: when wr_en && wr_ready, mem[wr_adr] <= wr_data. wr_en while wr_ready=0 is dropped; the requester must hold it.
- Read/write same address, same cycle:
  - BYPASS=1 returns wr_data.
  - BYPASS=0 returns the prior contents.
  - A write during clear is not accepted, so no bypass applies.
- Clear FSM:
  - IDLE: clr_start → CLEAR, with counter=0, clr_busy=1, wr_ready=0.
  - CLEAR: writes INIT_VAL to mem[counter] each cycle and increments the counter. After address 2^ADDR_W−1 is written → DONE.
  - DONE: clr_done=1 for one cycle, clr_busy=0, wr_ready=1 → IDLE.
- clr_start in CLEAR or DONE is ignored. clr_start and wr_en in the same IDLE cycle: the write is accepted and the clear starts next cycle.
- Reads are allowed during clear; they return whatever the array holds at that moment.
- rst_n asserted mid-clear: FSM returns to IDLE immediately and asynchronously. The array is left partially cleared; no clr_done.
- The counter is ADDR_W+1 bits wide so termination is detected without wrap-around ambiguity.

## Timing
- Read latency: 1 + RD_PIPE cycles from rd_en to rd_valid/rd_data. Fully pipelined; one read per cycle.
- Write takes effect at the rising edge where it is accepted. A read of that address issued in the next cycle returns the new data.
- wr_ready is combinationally derived from FSM state only, with no dependence on wr_en.
- Clear duration: clr_start at cycle t gives clr_busy high from t+1 to t+2^ADDR_W inclusive, and clr_done at t+2^ADDR_W+1.
- RD_PIPE=1: rd_valid and rd_data move together through the extra stage, which also resets to 0.

## Structure
- Shared package instram_pkg: FSM state enum (IDLE, CLEAR, DONE) and default parameter constants.
- Sub-module instram_array: bare SDP array with a synchronous read and one write port (write-enable, address, data). It has no reset and contains the BYPASS mux. The clear engine and the external write port share its write port through a mux in the top level.
- Top level contains the FSM, counter, write mux and RD_PIPE stage.

## Test plan
- Reset then read: after rst_n rises, rd_en at addr 0x0000 gives rd_valid after 1 cycle (2 with RD_PIPE=1). rd_data stays 0 before that first read.
- Write then read: write 0xA5 to 0x1234, then read 0x1234 in the next cycle → rd_data=0xA5 one cycle later.
- Collision: same-cycle write 0x3C and read at 0x0010, old value 0x00 → BYPASS=1 returns 0x3C; BYPASS=0 returns 0x00.
- Clear (ADDR_W=4, INIT_VAL=0xFF):
  - clr_start → clr_busy for 16 cycles, clr_done one cycle later.
  - A write attempted mid-clear sees wr_ready=0 and is dropped.
  - All 16 addresses then read 0xFF.
- Reset mid-clear (ADDR_W=4): assert rst_n low at clear cycle 5 → clr_busy=0 immediately, no clr_done, addresses 0–4 read INIT_VAL and 5–15 keep their prior data.
- Back-to-back reads of 0..7 with RD_PIPE=1 → eight consecutive rd_valid pulses with data in address order, starting 2 cycles after the first rd_en.

Source files
------------

// File: rtl/instram_pkg.sv
// Shared types and default constants for the instram_dp instruction store.
package instram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDone
    } clr_state_e;

    localparam int unsigned DefAddrW  = 15;
    localparam int unsigned DefDataW  = 8;
    localparam int unsigned DefRdPipe = 0;
    localparam int unsigned DefBypass = 1;

endpackage

// File: rtl/instram_array.sv
// Bare simple-dual-port array: one write port, one synchronous read port, optional
// write-to-read bypass. No reset so the storage maps onto block RAM.
module instram_array
    import instram_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned BYPASS = DefBypass
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_adr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              byp_ok,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_adr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [Depth];
    logic              hit;

    // Clear-engine writes never bypass; only accepted external writes do.
    assign hit = (BYPASS != 0) && byp_ok && (wr_adr == rd_adr);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_adr] <= wr_data;
        end
        if (rd_en) begin
            if (hit) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_adr];
            end
        end
    end

endmodule

// File: rtl/instram_dp.sv
// Instruction store top: clear engine, shared write-port mux and optional read
// pipeline stage around the bare SDP array.
module instram_dp
    import instram_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DefAddrW,
    parameter int unsigned       DATA_W   = DefDataW,
    parameter int unsigned       RD_PIPE  = DefRdPipe,
    parameter int unsigned       BYPASS   = DefBypass,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_adr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_adr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done
);

    clr_state_e        state_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_nxt;
    logic              clr_busy_q;
    logic              clr_done_q;

    logic              clearing;
    logic              ext_we;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_wadr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic              vld_q;

    assign clearing = (state_q == StClear);
    assign wr_ready = !clearing;
    assign ext_we   = wr_en && wr_ready;
    assign cnt_nxt  = cnt_q + 1'b1;

    assign arr_we    = clearing || ext_we;
    assign arr_wadr  = clearing ? cnt_q[ADDR_W-1:0] : wr_adr;
    assign arr_wdata = clearing ? INIT_VAL : wr_data;

    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

    // The extra counter bit flags that the last address has just been written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    clr_done_q <= 1'b0;
                    if (clr_start) begin
                        state_q    <= StClear;
                        cnt_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                StClear: begin
                    cnt_q <= cnt_nxt;
                    if (cnt_nxt[ADDR_W]) begin
                        state_q    <= StDone;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    clr_done_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    instram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BYPASS (BYPASS)
    ) u_array (
        .clk     (clk),
        .we      (arr_we),
        .wr_adr  (arr_wadr),
        .wr_data (arr_wdata),
        .byp_ok  (ext_we),
        .rd_en   (rd_en),
        .rd_adr  (rd_adr),
        .rd_data (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= rd_en;
        end
    end

    if (RD_PIPE != 0) begin : g_pipe
        logic              pipe_vld_q;
        logic [DATA_W-1:0] pipe_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_vld_q  <= 1'b0;
                pipe_data_q <= '0;
            end else begin
                pipe_vld_q <= vld_q;
                if (vld_q) begin
                    pipe_data_q <= arr_rdata;
                end
            end
        end

        assign rd_valid = pipe_vld_q;
        assign rd_data  = pipe_data_q;
    end else begin : g_nopipe
        logic seen_q;

        // The array's read register has no reset; mask it until the first read lands.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                seen_q <= 1'b0;
            end else if (vld_q) begin
                seen_q <= 1'b1;
            end
        end

        assign rd_valid = vld_q;
        assign rd_data  = (seen_q || vld_q) ? arr_rdata : '0;
    end

endmodule
